// File: rtl/pipelinedec_pkg.sv
// Shared Hamming helpers for the pipelined syndrome corrector.
// Functions work on the widest supported codeword (M=6, N=63); callers
// zero-extend their word and truncate the result to their own width.
package pipelinedec_pkg;

    localparam int DEF_M = 4;
    localparam int MAX_M = 6;
    localparam int MAX_N = (1 << MAX_M) - 1;

    // XOR of the 1-based positions of every set bit in the codeword.
    function automatic logic [MAX_M-1:0] syndrome(input logic [MAX_N-1:0] word, input int m);
        logic [MAX_M-1:0] s;
        s = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if ((i < (1 << m) - 1) && word[i]) begin
                s = s ^ MAX_M'(i + 1);
            end
        end
        return s;
    endfunction

    // One-hot mask selecting bit syn-1; all zeros when syn is zero.
    function automatic logic [MAX_N-1:0] onehot_mask(input logic [MAX_M-1:0] syn, input int m);
        logic [MAX_N-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if ((i < (1 << m) - 1) && (int'(syn) == i + 1)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/pipelined_syndrome_corrector_xor_vec.sv
// Combinational W-bit XOR, used to flip the erroneous bit of a codeword.
module xor_vec #(
    parameter int W = 15
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/pipelined_syndrome_corrector.sv
// Three-stage pipelined Hamming single-error corrector with valid/ready
// handshake. Stage 1 captures the word, stage 2 forms the syndrome, stage 3
// flips the addressed bit. All stages advance together; bubbles are kept.
// Optional feature macro ERR_COUNT_EN adds a saturating 16-bit err_count
// output counting delivered words that needed correction.
module pipelined_syndrome_corrector
    import pipelinedec_pkg::*;
#(
    parameter  int M = DEF_M,
    localparam int N = (1 << M) - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_word,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_word,
    output logic [M-1:0]  out_syn,
    output logic          out_err
`ifdef ERR_COUNT_EN
    ,
    output logic [15:0]   err_count
`endif
);

    logic         adv;
    logic         vld_p0;
    logic         vld_p1;
    logic [N-1:0] word_p0;
    logic [N-1:0] word_p1;
    logic [M-1:0] syn_p1;
    logic [M-1:0] syn_c;
    logic [N-1:0] mask_c;
    logic [N-1:0] fixed_c;

    // The whole pipe moves whenever the output slot is empty or draining.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Valid bits travel with the data; reset drops every in-flight word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
        end
    end

    // Stage 1: capture the received codeword.
    always_ff @(posedge clk) begin
        if (adv) begin
            word_p0 <= in_word;
        end
    end

    // Stage 2: syndrome as an XOR tree over set-bit positions.
    assign syn_c = M'(syndrome(MAX_N'(word_p0), M));

    always_ff @(posedge clk) begin
        if (adv) begin
            word_p1 <= word_p0;
            syn_p1  <= syn_c;
        end
    end

    // Stage 3: decode syndrome to a one-hot mask and flip that bit.
    assign mask_c = N'(onehot_mask(MAX_M'(syn_p1), M));

    xor_vec #(.W(N)) u_fix (
        .a (word_p1),
        .b (mask_c),
        .y (fixed_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_word <= '0;
            out_syn  <= '0;
            out_err  <= 1'b0;
        end else if (adv) begin
            out_word <= fixed_c;
            out_syn  <= syn_p1;
            out_err  <= |syn_p1;
        end
    end

`ifdef ERR_COUNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count corrected words as they leave; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_err) begin
            err_count <= sat_inc(err_count);
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_syndrome_corrector.sv
// Scoreboard bench for pipelined_syndrome_corrector (M=4, N=15).
module tb_pipelined_syndrome_corrector;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_word;
    logic [3:0]  out_syn;
    logic        out_err;
`ifdef ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    pipelined_syndrome_corrector #(.M(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_syn   (out_syn),
        .out_err   (out_err)
`ifdef ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] w;
        logic [3:0]  s;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: compare on every output transfer, check hold while stalled.
    logic        held = 1'b0;
    logic [14:0] h_w;
    logic [3:0]  h_s;
    logic        h_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_word", 32'(out_word), 32'(h_w));
                chk("hold_syn", 32'(out_syn), 32'(h_s));
                chk("hold_err", 32'(out_err), 32'(h_e));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_word), 32'hDEAD);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("out_word", 32'(out_word), 32'(x.w));
                    chk("out_syn", 32'(out_syn), 32'(x.s));
                    chk("out_err", 32'(out_err), 32'(x.e));
                end
            end
            held = out_valid && !out_ready;
            h_w  = out_word;
            h_s  = out_syn;
            h_e  = out_err;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [14:0] w, input logic [14:0] ew, input logic [3:0] es, input logic ee);
        int t;
        exp_t x;
        in_valid = 1'b1;
        in_word  = w;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 40) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        x.w = ew; x.s = es; x.e = ee;
        sb.push_back(x);
        acc++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", 32'(out_word), 32'd0);
        chk("rst_out_syn", 32'(out_syn), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ERR_COUNT_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: clean zero word, latency 3
        send(15'h0000, 15'h0000, 4'd0, 1'b0);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        drain();

        // 2: single flip at position 5
        send(15'h7FEF, 15'h7FFF, 4'd5, 1'b1);
        drain();

        // 3: back-to-back, one word per clock out
        send(15'h7FFE, 15'h7FFF, 4'd1, 1'b1);
        send(15'h3FFF, 15'h7FFF, 4'd15, 1'b1);
        send(15'h7FFF, 15'h7FFF, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        chk("b2b_tail", 32'(out_valid), 32'd0);
        drain();

        // 4: downstream stall, 5 words offered
        out_ready = 1'b0;
        acc = 0;
        fork
            begin
                send(15'h0004, 15'h0000, 4'd3, 1'b1);
                send(15'h7FBF, 15'h7FFF, 4'd7, 1'b1);
                send(15'h0100, 15'h0000, 4'd9, 1'b1);
                send(15'h77FF, 15'h7FFF, 4'd12, 1'b1);
                send(15'h0002, 15'h0000, 4'd2, 1'b1);
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("stall_accepted", 32'(acc), 32'd3);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // 5: reset with two words in flight
        send(15'h1000, 15'h0000, 4'd13, 1'b1);
        send(15'h7FFB, 15'h7FFF, 4'd3, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(15'h0040, 15'h0000, 4'd7, 1'b1);
        drain();

`ifdef ERR_COUNT_EN
        // 6: counter saturation
        force dut.err_count = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.err_count;
        send(15'h0001, 15'h0000, 4'd1, 1'b1);
        send(15'h0010, 15'h0000, 4'd5, 1'b1);
        send(15'h7FF7, 15'h7FFF, 4'd4, 1'b1);
        drain();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("err_count_sat", 32'(err_count), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
